// File: rtl/rr_arb8_mux_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter with 8:1 data select.
package rr_arb8_mux_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb8_mux_pick8.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping 7->0.
module rr_pick8
  import rr_arb8_mux_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest to nearest offset so the nearest set bit is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arb8_mux.sv
// 8-requester round-robin arbiter with bounded hold time, timeout pulse and 8:1 data mux.
module rr_arb8_mux
  import rr_arb8_mux_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             rel,
  input  logic [NREQ-1:0]  d,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_vld,
  output logic             y,
  output logic             tout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic             tout_q, tout_d;

  logic [SEL_W-1:0] winner_c;
  logic             any_c;
  logic             hold_done_c;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner_c),
    .any    (any_c)
  );

  assign hold_done_c = (cnt_q == HOLD_LAST);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        vld_d = 1'b0;
        cnt_d = '0;
        if (any_c) begin
          state_d = GRANT;
          gnt_d   = onehot(winner_c);
          sel_d   = winner_c;
          vld_d   = 1'b1;
        end
      end
      GRANT: begin
        if (rel || !req[sel_q] || hold_done_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
          // Only a forced end while the owner still wants the bus counts as a timeout.
          tout_d  = hold_done_c && !rel && req[sel_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign gnt_vld = vld_q;
  assign tout    = tout_q;

  // Unregistered data select, forced low without an owner.
  assign y = vld_q ? d[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_arb8_mux.sv
// Directed self-checking bench for rr_arb8_mux (HOLD_MAX 15, 4 and 1 instances).
module tb_rr_arb8_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] d;

  logic [7:0] gnt, gnt4, gnt1;
  logic [2:0] sel, sel4, sel1;
  logic       gnt_vld, gnt_vld4, gnt_vld1;
  logic       y, y4, y1;
  logic       tout, tout4, tout1;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rr_arb8_mux u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .d(d),
    .gnt(gnt), .sel(sel), .gnt_vld(gnt_vld), .y(y), .tout(tout)
  );

  rr_arb8_mux #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .d(d),
    .gnt(gnt4), .sel(sel4), .gnt_vld(gnt_vld4), .y(y4), .tout(tout4)
  );

  rr_arb8_mux #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .d(d),
    .gnt(gnt1), .sel(sel1), .gnt_vld(gnt_vld1), .y(y1), .tout(tout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Structural invariants on every instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot",   32'($onehot0(gnt)),  32'd1);
      chk("vld_eq",   32'(gnt_vld),        32'(|gnt));
      chk("onehot4",  32'($onehot0(gnt4)), 32'd1);
      chk("vld_eq4",  32'(gnt_vld4),       32'(|gnt4));
      chk("vld_eq1",  32'(gnt_vld1),       32'(|gnt1));
    end
  end

  logic [7:0] exp4_gnt  [6] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10};
  logic       exp4_tout [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    d     = '0;
    tick();
    tick();
    mon_en = 1'b1;

    // Reset state
    chk("rst_gnt",  32'(gnt),     32'h0);
    chk("rst_vld",  32'(gnt_vld), 32'h0);
    chk("rst_sel",  32'(sel),     32'h0);
    chk("rst_tout", 32'(tout),    32'h0);
    chk("rst_y",    32'(y),       32'h0);

    // Single requester 0, release in third grant cycle
    rst_n = 1'b1;
    req   = 8'h01;
    tick();
    chk("r0_gnt", 32'(gnt),     32'h01);
    chk("r0_sel", 32'(sel),     32'h0);
    chk("r0_vld", 32'(gnt_vld), 32'h1);
    d = 8'h01;
    #1 chk("r0_y1", 32'(y), 32'h1);
    d = 8'hFE;
    #1 chk("r0_y0", 32'(y), 32'h0);
    tick();
    chk("r0_hold2", 32'(gnt), 32'h01);
    tick();
    chk("r0_hold3", 32'(gnt), 32'h01);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("r0_exit",  32'(gnt),  32'h0);
    chk("r0_tout",  32'(tout), 32'h0);
    chk("r0_y_off", 32'(y),    32'h0);
    req = 8'h03;
    tick();
    chk("r0_ptr1", 32'(gnt), 32'h02);
    chk("r0_sel1", 32'(sel), 32'h1);
    req = 8'h00;
    tick();
    chk("drop_gnt",  32'(gnt),  32'h0);
    chk("drop_tout", 32'(tout), 32'h0);

    // All requesting, release each grant immediately: strict rotation
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << (i % 8));
      chk("rr_sel", 32'(sel), 32'(i % 8));
      rel = 1'b1;
      tick();
      rel = 1'b0;
      chk("rr_dead", 32'(gnt), 32'h0);
    end

    // Timeout with HOLD_MAX=4 and HOLD_MAX=1, owner 4 never releases
    do_reset();
    d   = 8'h10;
    req = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("to4_gnt",  32'(gnt4),  32'(exp4_gnt[i]));
      chk("to4_tout", 32'(tout4), 32'(exp4_tout[i]));
      chk("to4_sel",  32'(sel4),  32'h4);
      chk("to4_y",    32'(y4),    32'(exp4_gnt[i] != 8'h00));
      chk("to1_gnt",  32'(gnt1),  (i % 2 == 0) ? 32'h10 : 32'h0);
      chk("to1_tout", 32'(tout1), 32'(i % 2));
      chk("to1_sel",  32'(sel1),  32'h4);
      chk("to1_y",    32'(y1),    (i % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Pointer wrap: grant 6 then release leaves ptr=7; 7 wins, then 0
    do_reset();
    req = 8'h40;
    tick();
    chk("wr_g6", 32'(gnt), 32'h40);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = 8'h81;
    tick();
    chk("wr_g7", 32'(gnt), 32'h80);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("wr_dead", 32'(gnt), 32'h0);
    tick();
    chk("wr_g0",  32'(gnt), 32'h01);
    chk("wr_s0",  32'(sel), 32'h0);

    // Owner 3 drops request; other bits ignored during grant
    do_reset();
    req = 8'h08;
    tick();
    chk("dr_g3", 32'(gnt), 32'h08);
    req = 8'h09;
    tick();
    chk("dr_ignore", 32'(gnt), 32'h08);
    req = 8'h01;
    tick();
    chk("dr_gnt",  32'(gnt),  32'h0);
    chk("dr_tout", 32'(tout), 32'h0);
    tick();
    chk("dr_next", 32'(gnt), 32'h01);

    // Release coincident with timeout on HOLD_MAX=4: no tout
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 4; i++) tick();
    chk("rt_hold", 32'(gnt4), 32'h10);
    rel = 1'b1;
    tick();
    rel = 1'b0;
    chk("rt_gnt",  32'(gnt4),  32'h0);
    chk("rt_tout", 32'(tout4), 32'h0);
    tick();
    chk("rt_regnt", 32'(gnt4),  32'h10);
    chk("rt_tout2", 32'(tout4), 32'h0);

    // Asynchronous reset mid-grant
    do_reset();
    d   = 8'h08;
    req = 8'h08;
    tick();
    chk("ar_pre_y", 32'(y), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_gnt",  32'(gnt),     32'h0);
    chk("ar_vld",  32'(gnt_vld), 32'h0);
    chk("ar_y",    32'(y),       32'h0);
    chk("ar_tout", 32'(tout),    32'h0);
    tick();
    rst_n = 1'b1;
    req   = 8'h84;
    tick();
    chk("ar_first", 32'(gnt), 32'h04);
    chk("ar_sel",   32'(sel), 32'h2);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
